// File: rtl/eclk_pkg.sv
// Shared types and width helpers for the edge-clock switch sequencer.
package eclk_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STOP    = 2'd1,
    SWITCH  = 2'd2,
    RESTART = 2'd3
  } eclk_sw_state_t;

  // Counter width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/eclk_switch_seq_chk.sv
// Property checker: the clock select may only move while the edge clock is gated.
module eclk_switch_seq_chk #(
  parameter int SEL_W = 1
) (
  input logic             clk,
  input logic             rst,
  input logic [SEL_W-1:0] sel,
  input logic             eclk_stop
);

  sel_only_when_gated: assert property (
    @(posedge clk) disable iff (rst)
    (sel != $past(sel)) |-> ($past(eclk_stop) && eclk_stop)
  ) else $error("sel changed while edge clock was not gated");

endmodule

// File: rtl/eclk_wait_cnt.sv
// Loadable down-counter that parks at zero; shared by every sequencer state.
module eclk_wait_cnt #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_r;

  // Load on state entry, otherwise count down and hold at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {W{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (cnt_r != {W{1'b0}}) begin
      cnt_r <= cnt_r - {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero = (cnt_r == {W{1'b0}});

endmodule

// File: rtl/eclk_switch_seq.sv
// Glitch-free edge-clock source switch: gate, change select while gated,
// let the mux settle, ungate, then report completion.
module eclk_switch_seq
  import eclk_pkg::*;
#(
  parameter int NUM_SRC        = 2,
  parameter int SEL_W          = $clog2(NUM_SRC),
  parameter int STOP_CYCLES    = 4,
  parameter int SETTLE_CYCLES  = 4,
  parameter int RESTART_CYCLES = 2,
  parameter int RESET_SEL      = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [SEL_W-1:0] req_sel,
  output logic             req_ready,
  output logic [SEL_W-1:0] sel,
  output logic             eclk_stop,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int CNT_W = clog2_min1(max3(STOP_CYCLES, SETTLE_CYCLES, RESTART_CYCLES) + 1);
  localparam logic [CNT_W-1:0] STOP_LD    = CNT_W'(STOP_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RESTART_LD = (RESTART_CYCLES > 0) ? CNT_W'(RESTART_CYCLES - 1)
                                                                 : {CNT_W{1'b0}};
  localparam logic [SEL_W:0]   NUM_SRC_X  = (SEL_W + 1)'(NUM_SRC);
  localparam logic [SEL_W-1:0] RESET_SEL_L = SEL_W'(RESET_SEL);

  eclk_sw_state_t   state_r;
  logic [SEL_W-1:0] sel_r;
  logic [SEL_W-1:0] pend_r;
  logic             stop_r;
  logic             busy_r;
  logic             done_r;
  logic             err_r;

  logic             zero_s;
  logic             load_s;
  logic [CNT_W-1:0] load_val_s;
  logic             idx_bad_s;
  logic             same_s;

  // Index check is done one bit wider so a power-of-two NUM_SRC compares cleanly.
  assign idx_bad_s = ({1'b0, req_sel} >= NUM_SRC_X);
  assign same_s    = (req_sel == sel_r);

  eclk_wait_cnt #(.W(CNT_W)) u_wait_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (load_s),
    .load_val (load_val_s),
    .zero     (zero_s)
  );

  // Counter reload value for whichever state is entered on this edge.
  always_comb begin
    load_s     = 1'b0;
    load_val_s = {CNT_W{1'b0}};
    case (state_r)
      IDLE: begin
        if (req_valid && !idx_bad_s && !same_s) begin
          load_s     = 1'b1;
          load_val_s = STOP_LD;
        end else begin
          load_s     = 1'b0;
        end
      end
      STOP: begin
        if (zero_s) begin
          load_s     = 1'b1;
          load_val_s = SETTLE_LD;
        end else begin
          load_s     = 1'b0;
        end
      end
      SWITCH: begin
        if (zero_s) begin
          load_s     = 1'b1;
          load_val_s = RESTART_LD;
        end else begin
          load_s     = 1'b0;
        end
      end
      RESTART: begin
        if (zero_s) begin
          load_s     = 1'b1;
          load_val_s = {CNT_W{1'b0}};
        end else begin
          load_s     = 1'b0;
        end
      end
      default: begin
        load_s     = 1'b1;
        load_val_s = {CNT_W{1'b0}};
      end
    endcase
  end

  // Sequencer state and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      sel_r   <= RESET_SEL_L;
      pend_r  <= RESET_SEL_L;
      stop_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            if (idx_bad_s) begin
              err_r <= 1'b1;
            end else if (same_s) begin
              done_r <= 1'b1;
            end else begin
              pend_r  <= req_sel;
              stop_r  <= 1'b1;
              busy_r  <= 1'b1;
              state_r <= STOP;
            end
          end
        end
        STOP: begin
          // The select only moves here, after the full gated hold.
          if (zero_s) begin
            sel_r   <= pend_r;
            state_r <= SWITCH;
          end
        end
        SWITCH: begin
          if (zero_s) begin
            stop_r <= 1'b0;
            if (RESTART_CYCLES == 0) begin
              done_r  <= 1'b1;
              busy_r  <= 1'b0;
              state_r <= IDLE;
            end else begin
              state_r <= RESTART;
            end
          end
        end
        RESTART: begin
          if (zero_s) begin
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          stop_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign req_ready = (state_r == IDLE);
  assign sel       = sel_r;
  assign eclk_stop = stop_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign err       = err_r;

endmodule

// File: tb/tb_eclk_switch_seq.sv
// Scoreboard bench for eclk_switch_seq across default, 3-source and minimal-timing builds.
module tb_eclk_switch_seq;

  typedef struct {
    int kind;     // 1 = done, 2 = err
    int done_j;   // cycle index after acceptance edge where the pulse is seen
    int sel;
    int stop_n;
    int chg_j;
    int busy_n;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       rv0, rv1, rv2;
  logic [0:0] rs0, rs2;
  logic [1:0] rs1;
  logic       rdy0, rdy1, rdy2, stop0, stop1, stop2;
  logic       busy0, busy1, busy2, done0, done1, done2, err0, err1, err2;
  logic [0:0] sel0, sel2;
  logic [1:0] sel1;

  eclk_switch_seq #(.NUM_SRC(2)) u_dut0 (
    .clk(clk), .rst(rst), .req_valid(rv0), .req_sel(rs0), .req_ready(rdy0),
    .sel(sel0), .eclk_stop(stop0), .busy(busy0), .done(done0), .err(err0));
  eclk_switch_seq #(.NUM_SRC(3)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(rv1), .req_sel(rs1), .req_ready(rdy1),
    .sel(sel1), .eclk_stop(stop1), .busy(busy1), .done(done1), .err(err1));
  eclk_switch_seq #(.NUM_SRC(2), .STOP_CYCLES(1), .SETTLE_CYCLES(1), .RESTART_CYCLES(0)) u_dut2 (
    .clk(clk), .rst(rst), .req_valid(rv2), .req_sel(rs2), .req_ready(rdy2),
    .sel(sel2), .eclk_stop(stop2), .busy(busy2), .done(done2), .err(err2));

  eclk_switch_seq_chk #(.SEL_W(1)) u_chk0 (.clk(clk), .rst(rst), .sel(sel0), .eclk_stop(stop0));
  eclk_switch_seq_chk #(.SEL_W(2)) u_chk1 (.clk(clk), .rst(rst), .sel(sel1), .eclk_stop(stop1));
  eclk_switch_seq_chk #(.SEL_W(1)) u_chk2 (.clk(clk), .rst(rst), .sel(sel2), .eclk_stop(stop2));

  int p_nsrc[3]    = '{2, 3, 2};
  int p_stop[3]    = '{4, 4, 1};
  int p_settle[3]  = '{4, 4, 1};
  int p_restart[3] = '{2, 2, 0};
  int m_sel[3]     = '{0, 0, 0};

  int   cur = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  exp_t sbq[$];

  logic [3:0] o_sel;
  logic       o_rdy, o_stop, o_busy, o_done, o_err;

  // Route the instance under test onto one set of observation wires.
  always_comb begin
    case (cur)
      0: begin
        o_sel = {3'b000, sel0}; o_rdy = rdy0; o_stop = stop0;
        o_busy = busy0; o_done = done0; o_err = err0;
      end
      1: begin
        o_sel = {2'b00, sel1}; o_rdy = rdy1; o_stop = stop1;
        o_busy = busy1; o_done = done1; o_err = err1;
      end
      default: begin
        o_sel = {3'b000, sel2}; o_rdy = rdy2; o_stop = stop2;
        o_busy = busy2; o_done = done2; o_err = err2;
      end
    endcase
  end

  task automatic check_val(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic drive(input int idx, input bit v, input int s);
    case (idx)
      0: begin rv0 = v; rs0 = s[0:0]; end
      1: begin rv1 = v; rs1 = s[1:0]; end
      default: begin rv2 = v; rs2 = s[0:0]; end
    endcase
  endtask

  // Expected outcome of one request against the reference select model.
  task automatic predict(input int idx, input int s);
    exp_t e;
    int   lat;
    lat = p_stop[idx] + p_settle[idx] + p_restart[idx];
    if (s >= p_nsrc[idx])   e = '{2, 0, m_sel[idx], 0, -1, 0};
    else if (s == m_sel[idx]) e = '{1, 0, m_sel[idx], 0, -1, 0};
    else begin
      e = '{1, lat, s, p_stop[idx] + p_settle[idx], p_stop[idx], lat};
      m_sel[idx] = s;
    end
    sbq.push_back(e);
  endtask

  task automatic do_req(input int idx, input int s, input string tag);
    exp_t e;
    int   j, kind, lat, stop_n, busy_n, chg_j, sel_before, stop_at_chg, rdy_at_done;
    bit   fin;
    cur = idx;
    predict(idx, s);
    @(posedge clk); #1;
    drive(idx, 1'b1, s);
    @(negedge clk);
    check_val({tag, "_ready"}, int'(o_rdy), 1);
    sel_before = int'(o_sel);
    @(posedge clk); #1;
    drive(idx, 1'b0, 0);
    fin = 1'b0; j = 0; kind = 0; lat = -1; stop_n = 0; busy_n = 0;
    chg_j = -1; stop_at_chg = -1; rdy_at_done = -1;
    while (!fin && j < 60) begin
      @(negedge clk);
      if (o_stop) stop_n++;
      if (o_busy) busy_n++;
      if (chg_j < 0 && int'(o_sel) != sel_before) begin
        chg_j = j; stop_at_chg = int'(o_stop);
      end
      if (o_done || o_err) begin
        kind = int'({o_err, o_done}); lat = j; rdy_at_done = int'(o_rdy); fin = 1'b1;
      end
      j++;
    end
    check_val({tag, "_finished"}, int'(fin), 1);
    e = sbq.pop_front();
    check_val({tag, "_kind"}, kind, e.kind);
    check_val({tag, "_latency"}, lat, e.done_j);
    check_val({tag, "_sel"}, int'(o_sel), e.sel);
    check_val({tag, "_stop_cycles"}, stop_n, e.stop_n);
    check_val({tag, "_sel_change_cycle"}, chg_j, e.chg_j);
    check_val({tag, "_busy_cycles"}, busy_n, e.busy_n);
    check_val({tag, "_ready_at_done"}, rdy_at_done, 1);
    if (e.chg_j >= 0) check_val({tag, "_gated_at_change"}, stop_at_chg, 1);
  endtask

  initial begin
    exp_t e;
    int   ndone, stop_n, overlap, lat;
    rst = 1'b1;
    rv0 = 1'b0; rv1 = 1'b0; rv2 = 1'b0;
    rs0 = 1'b0; rs1 = 2'b00; rs2 = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_busy_held", int'(o_busy), 0);
    rst = 1'b0;
    @(negedge clk);
    check_val("rst_sel", int'(o_sel), 0);
    check_val("rst_stop", int'(o_stop), 0);
    check_val("rst_ready", int'(o_rdy), 1);
    check_val("rst_done", int'(o_done), 0);
    check_val("rst_err", int'(o_err), 0);

    do_req(0, 1, "sw01");
    do_req(0, 1, "same1");
    do_req(0, 0, "sw10");

    // Second request held through a busy switch; it must wait for req_ready.
    cur = 0;
    lat = p_stop[0] + p_settle[0] + p_restart[0];
    e = '{1, lat, 1, 0, 0, 0};         sbq.push_back(e);
    e = '{1, 2 * lat + 1, 0, 0, 0, 0}; sbq.push_back(e);
    @(posedge clk); #1;
    drive(0, 1'b1, 1);
    @(posedge clk); #1;
    drive(0, 1'b1, 0);
    ndone = 0; stop_n = 0; overlap = 0;
    for (int j = 0; j < 80 && ndone < 2; j++) begin
      @(negedge clk);
      if (o_stop) stop_n++;
      if (o_busy && o_rdy) overlap++;
      if (ndone == 1 && o_busy) drive(0, 1'b0, 0);
      if (o_done) begin
        e = sbq.pop_front();
        check_val("held_done_cycle", j, e.done_j);
        check_val("held_sel", int'(o_sel), e.sel);
        ndone++;
      end
    end
    drive(0, 1'b0, 0);
    check_val("held_done_count", ndone, 2);
    check_val("held_stop_cycles", stop_n, 2 * (p_stop[0] + p_settle[0]));
    check_val("held_ready_while_busy", overlap, 0);

    do_req(1, 3, "bad3");
    do_req(1, 2, "sw02");
    do_req(1, 1, "sw21");
    do_req(2, 1, "fast01");
    do_req(2, 0, "fast10");

    // Asynchronous reset taken while the select is already switched but still gated.
    cur = 0;
    @(posedge clk); #1;
    drive(0, 1'b1, 1);
    @(posedge clk); #1;
    drive(0, 1'b0, 0);
    repeat (p_stop[0] + 2) @(negedge clk);
    check_val("mid_switch_sel", int'(o_sel), 1);
    check_val("mid_switch_stop", int'(o_stop), 1);
    #1 rst = 1'b1;
    #1;
    check_val("async_rst_stop", int'(o_stop), 0);
    check_val("async_rst_sel", int'(o_sel), 0);
    check_val("async_rst_busy", int'(o_busy), 0);
    check_val("async_rst_ready", int'(o_rdy), 1);
    m_sel = '{0, 0, 0};
    @(negedge clk);
    rst = 1'b0;
    do_req(0, 1, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
